// File: rtl/i2s_tx_stream.sv
// i2s_tx_stream: stereo I2S / left-justified serial transmitter for external
// audio DACs. A one-deep holding buffer takes L/R pairs over valid/ready, an
// integer divider derives BCK from clk, and each frame load latches the pair
// for serialisation MSB first. frame_strobe/underrun report every load.
module i2s_tx_stream #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned FORMAT   = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  input  logic                mute,
  output logic                bck,
  output logic                lrck,
  output logic                din,
  output logic                frame_strobe,
  output logic                underrun
);

  if (SAMPLE_W < 8 || SAMPLE_W > 32 || SLOT_W < SAMPLE_W || SLOT_W > 32 ||
      CLK_DIV < 1 || FORMAT > 1) begin : g_bad_params
    $error("i2s_tx_stream: illegal parameter combination");
  end

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned B_W   = $clog2(2 * SLOT_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [B_W-1:0]   B_LAST   = B_W'(2 * SLOT_W - 1);
  localparam logic [B_W-1:0]   SLOT_B   = B_W'(SLOT_W);
  localparam logic [B_W-1:0]   LOAD_B   = (FORMAT != 0) ? B_LAST : '0;

  logic [DIV_W-1:0]    div_q, div_d;
  logic                bck_q, bck_d;
  logic [B_W-1:0]      b_q, b_d;
  logic                lrck_q, lrck_d;
  logic                din_q, din_d;
  logic                started_q, started_d;
  logic                buf_full_q, buf_full_d;
  logic                s_ready_q, s_ready_d;
  logic [SAMPLE_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [SAMPLE_W-1:0] fr_l_q, fr_l_d, fr_r_q, fr_r_d;
  logic                strobe_q, strobe_d;
  logic                underrun_q, underrun_d;

  logic                toggle, rise, fall, load, accept, consume;
  logic [B_W-1:0]      b_next, p, k;
  logic                ch_r;
  logic [SAMPLE_W-1:0] word, shifted;

  // Next-state: divider, bit counter, serialiser, holding buffer, frame load.
  always_comb begin
    toggle  = (div_q == DIV_LAST);
    rise    = toggle & ~bck_q;
    fall    = toggle & bck_q;
    load    = rise & (b_q == LOAD_B);
    accept  = s_valid & s_ready_q;
    // A load before the first BCK falling edge after reset never consumes the
    // buffer, so the first frame after reset is always silent.
    consume = load & buf_full_q & started_q;

    div_d     = toggle ? '0 : div_q + 1'b1;
    bck_d     = bck_q ^ toggle;
    b_next    = (b_q == B_LAST) ? '0 : b_q + 1'b1;
    b_d       = fall ? b_next : b_q;
    started_d = started_q | fall;

    p       = (FORMAT != 0) ? b_next : ((b_next == '0) ? B_LAST : b_next - 1'b1);
    ch_r    = (p >= SLOT_B);
    k       = ch_r ? p - SLOT_B : p;
    word    = ch_r ? fr_r_q : fr_l_q;
    // Bits beyond SAMPLE_W shift out, giving the zero-padded slot tail.
    shifted = word << k;
    lrck_d  = fall ? (b_next >= SLOT_B) : lrck_q;
    din_d   = fall ? shifted[SAMPLE_W-1] : din_q;

    buf_full_d = buf_full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    if (consume) buf_full_d = 1'b0;
    if (accept) begin
      buf_full_d = 1'b1;
      buf_l_d    = s_left;
      buf_r_d    = s_right;
    end
    s_ready_d = ~buf_full_d;

    fr_l_d = fr_l_q;
    fr_r_d = fr_r_q;
    if (load) begin
      fr_l_d = (consume & ~mute) ? buf_l_q : '0;
      fr_r_d = (consume & ~mute) ? buf_r_q : '0;
    end
    strobe_d   = load;
    underrun_d = load & ~consume;
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= '0;
      bck_q      <= 1'b0;
      b_q        <= '0;
      lrck_q     <= 1'b0;
      din_q      <= 1'b0;
      started_q  <= 1'b0;
      buf_full_q <= 1'b0;
      s_ready_q  <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      fr_l_q     <= '0;
      fr_r_q     <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      bck_q      <= bck_d;
      b_q        <= b_d;
      lrck_q     <= lrck_d;
      din_q      <= din_d;
      started_q  <= started_d;
      buf_full_q <= buf_full_d;
      s_ready_q  <= s_ready_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      fr_l_q     <= fr_l_d;
      fr_r_q     <= fr_r_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  assign s_ready      = s_ready_q;
  assign bck          = bck_q;
  assign lrck         = lrck_q;
  assign din          = din_q;
  assign frame_strobe = strobe_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx_stream.sv
// Testbench for i2s_tx_stream: two configurations (I2S 32-bit slots /4 divider,
// left-justified 16-bit slots /1 divider) against an arithmetic reference of
// the BCK timeline plus a scoreboard of expected frames.
module tb_i2s_tx_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          done [2];

  typedef struct {
    bit          ur;
    logic [15:0] l;
    logic [15:0] r;
  } frame_t;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s actual=timeout required=event at %0t", name, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int FMT       = (g == 0) ? 0 : 1;
    localparam int SW        = (g == 0) ? 32 : 16;
    localparam int CD        = (g == 0) ? 4 : 1;
    localparam int FRAME_CLK = 4 * CD * SW;

    logic        reset_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        mute    = 1'b0;
    logic [15:0] s_left  = '0;
    logic [15:0] s_right = '0;
    logic        s_ready, bck, lrck, din, frame_strobe, underrun;
    string       pfx;

    i2s_tx_stream #(.SAMPLE_W(16), .SLOT_W(SW), .CLK_DIV(CD), .FORMAT(FMT)) u_dut (
      .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_left(s_left), .s_right(s_right), .mute(mute), .bck(bck), .lrck(lrck),
      .din(din), .frame_strobe(frame_strobe), .underrun(underrun)
    );

    // Reference: n = clk edges since release; BCK toggle t = n/CD, falls = t/2.
    int unsigned n = 0, m_b = 0, m_loads = 0, m_accs = 0;
    bit          m_full = 0, m_ready = 0, m_load = 0, m_ur = 0, m_acc = 0;
    bit          m_bck = 0, m_lrck = 0;
    logic [15:0] m_bl = '0, m_br = '0;
    frame_t      exp_q[$];

    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        n = 0; m_full = 0; m_ready = 0; m_load = 0; m_ur = 0; m_acc = 0;
        m_bck = 0; m_lrck = 0; m_b = 0;
        exp_q.delete();
      end else begin
        int unsigned t;
        bit          acc;
        n++;
        t = n / CD;
        acc = s_valid && m_ready;
        m_load = (n % CD == 0) && (t % 2 == 1) &&
                 (((t - 1) / 2) % (2 * SW) == ((FMT != 0) ? 2 * SW - 1 : 0));
        m_ur = 0;
        if (m_load) begin
          m_loads++;
          if (m_full && t >= 3) begin
            exp_q.push_back('{ur: 1'b0, l: (mute ? 16'h0 : m_bl), r: (mute ? 16'h0 : m_br)});
            m_full = 0;
          end else begin
            exp_q.push_back('{ur: 1'b1, l: 16'h0, r: 16'h0});
            m_ur = 1;
          end
        end
        if (acc) begin
          m_full = 1; m_bl = s_left; m_br = s_right; m_accs++;
        end
        m_acc   = acc;
        m_ready = !m_full;
        m_bck   = (t % 2) == 1;
        m_b     = (t / 2) % (2 * SW);
        m_lrck  = m_b >= SW;
      end
    end

    // Monitor: per-cycle timing checks, scoreboard pop on frame_strobe, bit checks on BCK falls.
    bit          mon_coll = 0, prev_bck = 0;
    int unsigned mon_idx = 0;
    frame_t      cur;
    logic [15:0] w, sh;
    logic        el;

    always @(negedge clk) begin
      if (!reset_n) begin
        chkw({pfx, "_reset_outs"}, 32'({bck, lrck, din, s_ready, frame_strobe, underrun}), 32'h0);
        mon_coll = 0;
        prev_bck = 0;
      end else begin
        chk1({pfx, "_bck"}, bck, m_bck);
        chk1({pfx, "_lrck"}, lrck, m_lrck);
        chk1({pfx, "_s_ready"}, s_ready, m_ready);
        chk1({pfx, "_frame_strobe"}, frame_strobe, m_load);
        chk1({pfx, "_underrun"}, underrun, m_ur);
        if (frame_strobe) begin
          if (exp_q.size() == 0) timeout({pfx, "_scoreboard_empty"});
          else begin
            cur = exp_q.pop_front();
            chk1({pfx, "_frame_underrun"}, underrun, cur.ur);
            mon_coll = 1;
            mon_idx  = 0;
          end
        end
        if (prev_bck && !bck) begin
          if (mon_coll) begin
            w  = (mon_idx >= SW) ? cur.r : cur.l;
            sh = w << (mon_idx % SW);
            el = (FMT != 0) ? (mon_idx >= SW) : (((mon_idx + 1) % (2 * SW)) >= SW);
            chk1($sformatf("%s_din_bit%0d", pfx, mon_idx), din, sh[15]);
            chk1($sformatf("%s_slot_lrck%0d", pfx, mon_idx), lrck, el);
            mon_idx++;
            if (mon_idx == 2 * SW) mon_coll = 0;
          end else begin
            chk1({pfx, "_idle_din"}, din, 1'b0);
          end
        end
        prev_bck = bck;
      end
    end

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
      int unsigned a0 = m_accs;
      int unsigned budget = 2 * FRAME_CLK + 8;
      s_valid = 1'b1; s_left = l; s_right = r;
      while (m_accs == a0 && budget > 0) begin step(); budget--; end
      s_valid = 1'b0;
      if (m_accs == a0) timeout({pfx, "_push_wait"});
    endtask

    task automatic wait_loads(input int unsigned k);
      int unsigned tgt = m_loads + k;
      int unsigned budget = (k + 1) * FRAME_CLK + 16;
      while (m_loads < tgt && budget > 0) begin step(); budget--; end
      if (m_loads < tgt) timeout({pfx, "_load_wait"});
    endtask

    task automatic stream(input int unsigned frames);
      logic [15:0] cnt = 16'($urandom);
      s_valid = 1'b1; s_left = cnt; s_right = cnt + 16'h8000;
      for (int unsigned c = 0; c < frames * FRAME_CLK; c++) begin
        step();
        if (m_acc) begin
          cnt++;
          s_left = cnt; s_right = cnt + 16'h8000;
        end
      end
      s_valid = 1'b0;
    endtask

    initial begin
      int unsigned budget;
      pfx = $sformatf("cfg%0d", g);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      // Single pair then starvation: one data frame, then underruns.
      push(16'hA5F0, 16'h0F5A);
      wait_loads(3);
      // Back-to-back incrementing pairs with backpressure.
      stream(6);
      wait_loads(1);
      // Mute for exactly one load, then a normal frame.
      push(16'h7FFF, 16'h8000);
      mute = 1'b1;
      wait_loads(1);
      mute = 1'b0;
      push(16'($urandom), 16'($urandom));
      wait_loads(2);
      // Starvation for three frames, then recovery.
      wait_loads(3);
      push(16'($urandom), 16'($urandom));
      wait_loads(2);
      // Random pushes and mute.
      for (int unsigned i = 0; i < 8; i++) begin
        logic mm = ($urandom_range(3) == 0);
        if ($urandom_range(3) != 0) push(16'($urandom), 16'($urandom));
        mute = mm;
        wait_loads(1);
        mute = 1'b0;
      end
      // Reset in mid-frame at bit counter 20 with a pair buffered.
      s_valid = 1'b1; s_left = 16'h1234; s_right = 16'h5678;
      budget = 2 * FRAME_CLK;
      while (m_b != 20 && budget > 0) begin step(); budget--; end
      if (m_b != 20) timeout({pfx, "_b20_wait"});
      s_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      chkw({pfx, "_async_reset_outs"}, 32'({bck, lrck, din, s_ready, frame_strobe, underrun}), 32'h0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      push(16'($urandom), 16'($urandom));
      wait_loads(3);
      done[g] = 1'b1;
    end
  end

  initial begin
    int unsigned cyc = 0;
    while (!(done[0] && done[1]) && cyc < 60000) begin
      @(posedge clk);
      cyc++;
    end
    if (!(done[0] && done[1])) timeout("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
